// File: rtl/key_breath_ctrl.sv
// Key debounce and 4-state breathing-mode control for the breath LED PWM stage.
// Latency: key_in fall to key_flag = 2 + CNT_20MS_MAX cycles; mode +1, decode +2.
// Backpressure: none; one flag per press is consumed unconditionally by the mode FSM.
module key_breath_ctrl #(
  parameter logic [19:0] CNT_20MS_MAX = 20'd999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic       key_flag,
  output logic [1:0] led_mode,
  output logic       breath_en,
  output logic       speed_sel,
  output logic       led_force
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_SLOW  = 2'b01,
    MODE_FAST  = 2'b10,
    MODE_SOLID = 2'b11
  } mode_t;

  logic        key_s1;
  logic        key_s2;
  logic [19:0] cnt_20ms;
  mode_t       mode_q;
  mode_t       mode_d;

  // Two-stage synchroniser; resets to the idle-high key level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_in;
      key_s2 <= key_s1;
    end
  end

  // Stable-low counter: clears on any high sample, saturates so a held key fires once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_20ms <= 20'd0;
    end else if (key_s2) begin
      cnt_20ms <= 20'd0;
    end else if (cnt_20ms < CNT_20MS_MAX) begin
      cnt_20ms <= cnt_20ms + 20'd1;
    end
  end

  // Single-cycle press pulse on the last count before saturation.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_flag <= 1'b0;
    end else begin
      key_flag <= !key_s2 && (cnt_20ms == CNT_20MS_MAX - 20'd1);
    end
  end

  // Mode state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q <= MODE_OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Next mode: step round OFF -> SLOW -> FAST -> SOLID on each accepted press.
  always_comb begin
    mode_d = mode_q;
    if (key_flag) begin
      case (mode_q)
        MODE_OFF:   mode_d = MODE_SLOW;
        MODE_SLOW:  mode_d = MODE_FAST;
        MODE_FAST:  mode_d = MODE_SOLID;
        MODE_SOLID: mode_d = MODE_OFF;
        default:    mode_d = MODE_OFF;
      endcase
    end
  end

  assign led_mode = mode_q;

  // Registered control decode; breath_en and led_force are mutually exclusive by construction.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      breath_en <= 1'b0;
      speed_sel <= 1'b0;
      led_force <= 1'b0;
    end else begin
      breath_en <= (mode_q == MODE_SLOW) || (mode_q == MODE_FAST);
      speed_sel <= (mode_q == MODE_FAST);
      led_force <= (mode_q == MODE_SOLID);
    end
  end

endmodule

// File: tb/tb_key_breath_ctrl.sv
// Directed bench for key_breath_ctrl with a 4-cycle debounce window.
// Latency: expected flag 6 cycles after key fall or reset release.
// Backpressure: not applicable.
module tb_key_breath_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_in;
  logic       key_flag;
  logic [1:0] led_mode;
  logic       breath_en;
  logic       speed_sel;
  logic       led_force;

  int check_cnt = 0;
  int pass_cnt  = 0;

  key_breath_ctrl #(.CNT_20MS_MAX(20'd4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .led_mode  (led_mode),
    .breath_en (breath_en),
    .speed_sel (speed_sel),
    .led_force (led_force)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Step n clocks, sampling 1 ns after each edge; count flag pulses and the first one's cycle.
  task automatic run_cycles(input int n, output int flags, output int first_at);
    flags = 0;
    first_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge sys_clk);
      #1;
      if (key_flag === 1'b1) begin
        flags++;
        if (first_at < 0) first_at = i;
      end
    end
  endtask

  task automatic do_reset();
    key_in = 1'b1;
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      @(posedge sys_clk);
      #1;
      check_cnt++;
      if (key_flag !== 1'b0) $display("FAIL idle_flag cyc %0d got %b want 0", i, key_flag);
      else pass_cnt++;
      check_cnt++;
      if (led_mode !== 2'b00) $display("FAIL idle_mode cyc %0d got %b want 00", i, led_mode);
      else pass_cnt++;
      check_cnt++;
      if (breath_en !== 1'b0) $display("FAIL idle_breath cyc %0d got %b want 0", i, breath_en);
      else pass_cnt++;
      check_cnt++;
      if (led_force !== 1'b0) $display("FAIL idle_force cyc %0d got %b want 0", i, led_force);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_press();
    int f1, fa1, f2, fa2;
    key_in = 1'b0;
    run_cycles(20, f1, fa1);
    key_in = 1'b1;
    run_cycles(10, f2, fa2);
    check_cnt++;
    if (f1 + f2 !== 1) $display("FAIL press_flag_count got %0d want 1", f1 + f2);
    else pass_cnt++;
    check_cnt++;
    if (fa1 !== 6) $display("FAIL press_latency got %0d want 6", fa1);
    else pass_cnt++;
    check_cnt++;
    if (led_mode !== 2'b01) $display("FAIL press_mode got %b want 01", led_mode);
    else pass_cnt++;
    check_cnt++;
    if (breath_en !== 1'b1) $display("FAIL press_breath got %b want 1", breath_en);
    else pass_cnt++;
    check_cnt++;
    if (speed_sel !== 1'b0) $display("FAIL press_speed got %b want 0", speed_sel);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int f1, f2, f3, f4, fa;
    key_in = 1'b0; run_cycles(3, f1, fa);
    key_in = 1'b1; run_cycles(1, f2, fa);
    key_in = 1'b0; run_cycles(3, f3, fa);
    key_in = 1'b1; run_cycles(10, f4, fa);
    check_cnt++;
    if (f1 + f2 + f3 + f4 !== 0) $display("FAIL bounce_flag got %0d want 0", f1 + f2 + f3 + f4);
    else pass_cnt++;
    check_cnt++;
    if (led_mode !== 2'b01) $display("FAIL bounce_mode got %b want 01", led_mode);
    else pass_cnt++;
  endtask

  task automatic test_four_presses();
    logic [1:0] exp_mode  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic       exp_br    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_sp    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_fo    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int f1, f2, fa;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      key_in = 1'b0; run_cycles(10, f1, fa);
      key_in = 1'b1; run_cycles(10, f2, fa);
      check_cnt++;
      if (f1 + f2 !== 1) $display("FAIL seq_flag p%0d got %0d want 1", p, f1 + f2);
      else pass_cnt++;
      check_cnt++;
      if (led_mode !== exp_mode[p]) $display("FAIL seq_mode p%0d got %b want %b", p, led_mode, exp_mode[p]);
      else pass_cnt++;
      check_cnt++;
      if (breath_en !== exp_br[p]) $display("FAIL seq_breath p%0d got %b want %b", p, breath_en, exp_br[p]);
      else pass_cnt++;
      check_cnt++;
      if (speed_sel !== exp_sp[p]) $display("FAIL seq_speed p%0d got %b want %b", p, speed_sel, exp_sp[p]);
      else pass_cnt++;
      check_cnt++;
      if (led_force !== exp_fo[p]) $display("FAIL seq_force p%0d got %b want %b", p, led_force, exp_fo[p]);
      else pass_cnt++;
      check_cnt++;
      if ((breath_en & led_force) !== 1'b0) $display("FAIL seq_exclusive p%0d got 1 want 0", p);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    int f1, fa1, f2, fa2;
    key_in = 1'b0;
    run_cycles(200, f1, fa1);
    check_cnt++;
    if (dut.cnt_20ms !== 20'd4) $display("FAIL hold_saturate got %0d want 4", dut.cnt_20ms);
    else pass_cnt++;
    key_in = 1'b1;
    run_cycles(10, f2, fa2);
    check_cnt++;
    if (f1 + f2 !== 1) $display("FAIL hold_flag_count got %0d want 1", f1 + f2);
    else pass_cnt++;
    check_cnt++;
    if (fa1 !== 6) $display("FAIL hold_latency got %0d want 6", fa1);
    else pass_cnt++;
    check_cnt++;
    if (led_mode !== 2'b01) $display("FAIL hold_mode got %b want 01", led_mode);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_press();
    int f1, fa1, f2, fa2;
    key_in = 1'b0; run_cycles(10, f1, fa1);
    key_in = 1'b1; run_cycles(10, f1, fa1);
    check_cnt++;
    if (led_mode !== 2'b10) $display("FAIL rst_pre_mode got %b want 10", led_mode);
    else pass_cnt++;
    key_in = 1'b0;
    run_cycles(3, f1, fa1);
    sys_rst_n = 1'b0;
    #1;
    check_cnt++;
    if (led_mode !== 2'b00) $display("FAIL rst_async_mode got %b want 00", led_mode);
    else pass_cnt++;
    check_cnt++;
    if ({key_flag, breath_en, speed_sel, led_force} !== 4'b0000)
      $display("FAIL rst_async_outs got %b want 0000", {key_flag, breath_en, speed_sel, led_force});
    else pass_cnt++;
    check_cnt++;
    if (dut.cnt_20ms !== 20'd0) $display("FAIL rst_async_cnt got %0d want 0", dut.cnt_20ms);
    else pass_cnt++;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    run_cycles(12, f1, fa1);
    key_in = 1'b1;
    run_cycles(10, f2, fa2);
    check_cnt++;
    if (f1 + f2 !== 1) $display("FAIL rst_flag_count got %0d want 1", f1 + f2);
    else pass_cnt++;
    check_cnt++;
    if (fa1 !== 6) $display("FAIL rst_latency got %0d want 6", fa1);
    else pass_cnt++;
    check_cnt++;
    if (led_mode !== 2'b01) $display("FAIL rst_post_mode got %b want 01", led_mode);
    else pass_cnt++;
  endtask

  initial begin
    key_in = 1'b1;
    sys_rst_n = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_four_presses();
    test_hold();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
